vidc_dma_capture: RTL and testbench

Parametrised, multi-channel successor to the VIDC register/DMA snooper's DMA path. It observes MEMC→VIDC DMA bursts on the VIDC pins for the video, cursor and sound channels. Each captured beat is presented as a tagged, registered output word, and per-frame burst counts are published. It sits between the pin synchronisers and the line/cursor/sound FIFOs.

---
 rtl/vidc_dma_capture.sv | 199 +++++++++++++++++++
 tb/tb_vidc_dma_capture.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vidc_dma_capture.sv
// VIDC DMA snooper: captures MEMC->VIDC video/cursor/sound burst beats and publishes per-frame burst counts.
// Optional macro VIDC_DMA_TIMEOUT_EN adds an inter-beat timeout that aborts a stalled burst.
`timescale 1ns/1ps
module vidc_dma_capture #(
  parameter int DATA_W         = 32,
  parameter int BURST_BEATS    = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] vidc_d,
  input  logic              vidc_nhs,
  input  logic              vidc_flybk,
  input  logic              vidc_nvidrq,
  input  logic              vidc_nvidak,
  input  logic              vidc_nsndrq,
  input  logic              vidc_nsndak,
  output logic              load_valid,
  output logic [1:0]        load_chan,
  output logic              load_last,
  output logic [DATA_W-1:0] load_data,
  output logic              busy,
  output logic [CNT_W-1:0]  video_cnt,
  output logic [CNT_W-1:0]  cursor_cnt,
  output logic [CNT_W-1:0]  sound_cnt,
  output logic [3:0]        fr_count,
  output logic              err_abort,
  input  logic              err_clr
);

  localparam int BW = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, VID = 2'd1, CUR = 2'd2, SND = 2'd3} state_e;

  // strobe vector: {nsndak, nsndrq, nvidak, nvidrq, flybk, nhs}
  logic [5:0]                         pins;
  logic [SYNC_STAGES-1:0][5:0]        sync_q;
  logic [2:0]                         hist_q;
  logic [SYNC_STAGES:0][DATA_W-1:0]   dpipe_q;
  logic [5:0]                         cur;

  assign pins = {vidc_nsndak, vidc_nsndrq, vidc_nvidak, vidc_nvidrq, vidc_flybk, vidc_nhs};
  assign cur  = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '1;
      hist_q  <= '1;
      dpipe_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pins};
      hist_q  <= {cur[5], cur[3], cur[1]};
      dpipe_q <= {dpipe_q[SYNC_STAGES-1:0], vidc_d};
    end
  end

  logic s_nhs, fb_rise, vid_req, snd_req, vid_beat, snd_beat, beat, abort;
  assign s_nhs    = cur[0];
  assign fb_rise  = cur[1] & ~hist_q[0];
  assign vid_req  = ~cur[2];
  assign vid_beat = cur[3] & ~hist_q[1];
  assign snd_req  = ~cur[4];
  assign snd_beat = cur[5] & ~hist_q[2];

  state_e          state_q, state_d;
  logic [BW-1:0]   bcnt_q;
  logic            vid_arm_q, snd_arm_q;
  logic [CNT_W-1:0] vcnt_q, ccnt_q, scnt_q;
  logic [CNT_W-1:0] video_cnt_q, cursor_cnt_q, sound_cnt_q;
  logic [3:0]      fr_q;
  logic            err_q;
  logic            load_valid_q, load_last_q;
  logic [1:0]      load_chan_q;
  logic [DATA_W-1:0] load_data_q;

  assign beat = (state_q == SND) ? snd_beat : vid_beat;

`ifdef VIDC_DMA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  // Counts idle cycles since the last beat; a beat on the limit cycle still wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                       tmo_q <= '0;
    else if (state_q == IDLE || beat)   tmo_q <= '0;
    else if (tmo_q != TW'(TIMEOUT_CYCLES)) tmo_q <= tmo_q + TW'(1);
  end

  assign abort = (state_q != IDLE) && !beat && (tmo_q == TW'(TIMEOUT_CYCLES));
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(TIMEOUT_CYCLES);
  assign abort      = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (vid_req && vid_arm_q)      state_d = s_nhs ? VID : CUR;
        else if (snd_req && snd_arm_q) state_d = SND;
      end
      default: begin
        if (abort)                     state_d = IDLE;
        else if (beat && bcnt_q == '0) state_d = IDLE;
      end
    endcase
  end

  // outputs (registered below)
  logic       load_valid_d, load_last_d;
  logic [1:0] load_chan_d;
  logic       ent_vid, ent_cur, ent_snd;

  always_comb begin
    load_valid_d = (state_q != IDLE) && beat;
    load_last_d  = load_valid_d && (bcnt_q == '0);
    load_chan_d  = 2'd0;
    if (state_q == CUR) load_chan_d = 2'd1;
    if (state_q == SND) load_chan_d = 2'd2;
    ent_vid = (state_q == IDLE) && (state_d == VID);
    ent_cur = (state_q == IDLE) && (state_d == CUR);
    ent_snd = (state_q == IDLE) && (state_d == SND);
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcnt_q       <= '0;
      vid_arm_q    <= 1'b1;
      snd_arm_q    <= 1'b1;
      vcnt_q       <= '0;
      ccnt_q       <= '0;
      scnt_q       <= '0;
      video_cnt_q  <= '0;
      cursor_cnt_q <= '0;
      sound_cnt_q  <= '0;
      fr_q         <= '0;
      err_q        <= 1'b0;
      load_valid_q <= 1'b0;
      load_last_q  <= 1'b0;
      load_chan_q  <= '0;
      load_data_q  <= '0;
    end else begin
      if (ent_vid || ent_cur || ent_snd) bcnt_q <= BW'(BURST_BEATS - 1);
      else if (load_valid_d)             bcnt_q <= bcnt_q - BW'(1);

      // re-arm only once the request has been seen inactive, so a held-low request can't retrigger
      vid_arm_q <= (ent_vid || ent_cur) ? 1'b0 : (vid_arm_q | ~vid_req);
      snd_arm_q <= ent_snd ? 1'b0 : (snd_arm_q | ~snd_req);

      if (fb_rise) begin
        video_cnt_q  <= vcnt_q;
        cursor_cnt_q <= ccnt_q;
        sound_cnt_q  <= scnt_q;
        vcnt_q       <= CNT_W'(ent_vid);
        ccnt_q       <= CNT_W'(ent_cur);
        scnt_q       <= CNT_W'(ent_snd);
        fr_q         <= fr_q + 4'd1;
      end else begin
        if (ent_vid) vcnt_q <= sat_inc(vcnt_q);
        if (ent_cur) ccnt_q <= sat_inc(ccnt_q);
        if (ent_snd) scnt_q <= sat_inc(scnt_q);
      end

      err_q        <= abort | (err_q & ~err_clr);
      load_valid_q <= load_valid_d;
      load_last_q  <= load_last_d;
      if (load_valid_d) begin
        load_chan_q <= load_chan_d;
        load_data_q <= dpipe_q[SYNC_STAGES];
      end
    end
  end

  assign load_valid = load_valid_q;
  assign load_last  = load_last_q;
  assign load_chan  = load_chan_q;
  assign load_data  = load_data_q;
  assign busy       = (state_q != IDLE);
  assign video_cnt  = video_cnt_q;
  assign cursor_cnt = cursor_cnt_q;
  assign sound_cnt  = sound_cnt_q;
  assign fr_count   = fr_q;
  assign err_abort  = err_q;

endmodule

// File: tb/tb_vidc_dma_capture.sv
// Randomised bench for vidc_dma_capture: beat scoreboard plus frame-level burst count model.
`timescale 1ns/1ps
module tb_vidc_dma_capture;
  localparam int DW = 32, BB = 4, S = 2, CW = 16;

  logic clk = 1'b0, reset_n = 1'b0;
  logic [DW-1:0] vidc_d = '0;
  logic vidc_nhs = 1'b1, vidc_flybk = 1'b0;
  logic vidc_nvidrq = 1'b1, vidc_nvidak = 1'b1, vidc_nsndrq = 1'b1, vidc_nsndak = 1'b1;
  logic err_clr = 1'b0;
  logic load_valid, load_last, busy, err_abort;
  logic [1:0] load_chan;
  logic [DW-1:0] load_data;
  logic [CW-1:0] video_cnt, cursor_cnt, sound_cnt;
  logic [3:0] fr_count;

  always #5 clk = ~clk;

  vidc_dma_capture #(.DATA_W(DW), .BURST_BEATS(BB), .SYNC_STAGES(S), .CNT_W(CW), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .reset_n(reset_n), .vidc_d(vidc_d), .vidc_nhs(vidc_nhs), .vidc_flybk(vidc_flybk),
    .vidc_nvidrq(vidc_nvidrq), .vidc_nvidak(vidc_nvidak), .vidc_nsndrq(vidc_nsndrq), .vidc_nsndak(vidc_nsndak),
    .load_valid(load_valid), .load_chan(load_chan), .load_last(load_last), .load_data(load_data),
    .busy(busy), .video_cnt(video_cnt), .cursor_cnt(cursor_cnt), .sound_cnt(sound_cnt),
    .fr_count(fr_count), .err_abort(err_abort), .err_clr(err_clr));

  typedef struct { logic [1:0] ch; logic [DW-1:0] d; logic last; } beat_t;
  beat_t exp_q[$];
  beat_t cmp_e;
  int n_chk = 0, n_err = 0;
  int mcnt[3], mpub[3], mfr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // every strobe must match the next expected beat
  always @(negedge clk) begin
    if (reset_n && load_valid) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL unexpected_beat: chan=%0d data=%h last=%0b with no beat pending", load_chan, load_data, load_last);
      end else begin
        cmp_e = exp_q.pop_front();
        chk("load_chan", 64'(load_chan), 64'(cmp_e.ch));
        chk("load_data", 64'(load_data), 64'(cmp_e.d));
        chk("load_last", 64'(load_last), 64'(cmp_e.last));
      end
    end
  end

  function automatic void model_fly();
    for (int c = 0; c < 3; c++) begin mpub[c] = mcnt[c]; mcnt[c] = 0; end
    mfr = (mfr + 1) % 16;
  endfunction

  task automatic check_counts();
    chk("video_cnt", 64'(video_cnt), 64'(mpub[0]));
    chk("cursor_cnt", 64'(cursor_cnt), 64'(mpub[1]));
    chk("sound_cnt", 64'(sound_cnt), 64'(mpub[2]));
    chk("fr_count", 64'(fr_count), 64'(mfr));
  endtask

  task automatic fly();
    vidc_flybk = 1'b1;
    model_fly();
    tick(3);
    vidc_flybk = 1'b0;
    tick(4);
    check_counts();
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20 && busy; k++) tick(1);
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic start_req(input int ch);
    if (ch != 2) begin
      vidc_nhs = (ch == 0);
      tick(4);
      vidc_nvidrq = 1'b0;
    end else vidc_nsndrq = 1'b0;
    mcnt[ch] = mcnt[ch] + 1;
  endtask

  task automatic run_acks(input int ch, input int n, input bit fixed);
    logic [DW-1:0] dat;
    for (int b = 0; b < n; b++) begin
      dat = fixed ? 32'h11111111 * (b + 1) : $urandom;
      vidc_d = dat;
      if (ch == 2) vidc_nsndak = 1'b0; else vidc_nvidak = 1'b0;
      tick($urandom_range(1, 3));
      if (ch == 2) vidc_nsndak = 1'b1; else vidc_nvidak = 1'b1;
      exp_q.push_back('{2'(ch), dat, (b == BB - 1)});
      for (int k = 0; k < 12 && exp_q.size() != 0; k++) tick(1);
      chk("beat_latency", 64'(exp_q.size()), 64'd0);
      if ($urandom_range(0, 2) == 0) begin
        if (ch == 2) vidc_nvidak = 1'b0; else vidc_nsndak = 1'b0;
        tick(1);
        vidc_nvidak = 1'b1; vidc_nsndak = 1'b1;
      end
      tick($urandom_range(1, 3));
    end
  endtask

  task automatic do_burst(input int ch, input bit fixed);
    start_req(ch);
    tick(5);
    chk("busy_in_burst", 64'(busy), 64'd1);
    vidc_nvidrq = 1'b1; vidc_nsndrq = 1'b1;
    run_acks(ch, BB, fixed);
    wait_idle();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int c = 0; c < 3; c++) begin mcnt[c] = 0; mpub[c] = 0; end
    mfr = 0;
    #2;
    chk("rst_load_valid", 64'(load_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_video_cnt", 64'(video_cnt), 64'd0);
    chk("rst_fr_count", 64'(fr_count), 64'd0);
    chk("rst_err_abort", 64'(err_abort), 64'd0);
    tick(3);
    reset_n = 1'b1;
    tick(4);

    // fixed-data video burst
    do_burst(0, 1'b1);
    fly();
    chk("tp_video_cnt1", 64'(video_cnt), 64'd1);

    // cursor then sound back-to-back
    do_burst(1, 1'b0);
    do_burst(2, 1'b0);
    fly();
    chk("tp_cursor_cnt1", 64'(cursor_cnt), 64'd1);
    chk("tp_sound_cnt1", 64'(sound_cnt), 64'd1);
    chk("tp_video_cnt0", 64'(video_cnt), 64'd0);

    // request held low across the burst end must not retrigger
    start_req(0);
    tick(5);
    run_acks(0, BB, 1'b0);
    wait_idle();
    tick(20);
    chk("stale_no_rearm", 64'(busy), 64'd0);
    vidc_nvidrq = 1'b1;
    tick(4);
    fly();
    chk("stale_video_cnt", 64'(video_cnt), 64'd1);

    // flyback start coincident with burst entry
    vidc_nhs = 1'b1;
    tick(4);
    vidc_flybk = 1'b1; vidc_nvidrq = 1'b0;
    model_fly();
    mcnt[0] = mcnt[0] + 1;
    tick(5);
    vidc_flybk = 1'b0; vidc_nvidrq = 1'b1;
    run_acks(0, BB, 1'b0);
    wait_idle();
    check_counts();
    chk("coinc_excluded", 64'(video_cnt), 64'd0);
    fly();
    chk("coinc_next_frame", 64'(video_cnt), 64'd1);

    // randomised traffic with stray acks in idle
    for (int it = 0; it < 16; it++) begin
      do_burst($urandom_range(0, 2), 1'b0);
      if ($urandom_range(0, 1) == 0) begin
        vidc_nvidak = 1'b0; vidc_nsndak = 1'b0;
        tick(2);
        vidc_nvidak = 1'b1; vidc_nsndak = 1'b1;
        tick(4);
      end
      if ($urandom_range(0, 2) == 0) fly();
    end
    for (int k = 0; k < 17; k++) fly();

    // reset mid-burst after two beats
    do_burst(1, 1'b0);
    start_req(0);
    tick(5);
    vidc_nvidrq = 1'b1;
    run_acks(0, 2, 1'b0);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_load_valid", 64'(load_valid), 64'd0);
    chk("mid_rst_load_data", 64'(load_data), 64'd0);
    chk("mid_rst_load_chan", 64'(load_chan), 64'd0);
    chk("mid_rst_cursor_cnt", 64'(cursor_cnt), 64'd0);
    chk("mid_rst_fr_count", 64'(fr_count), 64'd0);
    for (int c = 0; c < 3; c++) begin mcnt[c] = 0; mpub[c] = 0; end
    mfr = 0;
    exp_q.delete();
    tick(2);
    reset_n = 1'b1;
    tick(3);
    do_burst(0, 1'b1);
    fly();
    chk("post_rst_video_cnt", 64'(video_cnt), 64'd1);

`ifdef VIDC_DMA_TIMEOUT_EN
    start_req(0);
    tick(5);
    vidc_nvidrq = 1'b1;
    run_acks(0, 2, 1'b0);
    tick(300);
    chk("tmo_err_abort", 64'(err_abort), 64'd1);
    chk("tmo_busy", 64'(busy), 64'd0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    tick(1);
    chk("tmo_err_clr", 64'(err_abort), 64'd0);
`else
    chk("err_abort_idle", 64'(err_abort), 64'd0);
`endif
    chk("beats_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
